fetch_predict: RTL and testbench

- Parametrised successor to the pipeline's fetch stage: PC register, PC+4 adder and next-PC select, plus a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Fetch predicts branches instead of always fetching PC+4. EX-stage resolution updates the BTB and raises a flush/redirect on mispredict.
- Sits between the instruction memory (drives its address) and the IF/ID register.
- The hazard unit drives `stall`; the IF/ID and ID/EX registers consume `mispredict` as their flush.

---
 rtl/fetch_predict_pkg.sv | 23 ++
 rtl/btb_array.sv | 49 ++++
 rtl/fetch_predict.sv | 153 +++++++++++++++
 tb/tb_fetch_predict.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_predict_pkg.sv
// Shared encodings and sizing helpers for the predicting fetch stage and its BTB.
package fetch_predict_pkg;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = CTR_WT;
    localparam ctr_e CTR_RESET = CTR_WNT;

    function automatic int btb_tag_w(input int addr_w, input int depth);
        return addr_w - $clog2(depth) - 2;
    endfunction

    // Packed entry layout, MSB first: valid, tag, target, ctr.
    function automatic int btb_entry_w(input int addr_w, input int depth);
        return 1 + btb_tag_w(addr_w, depth) + addr_w + 2;
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: combinational read ports, one synchronous write
// port and a synchronous clear to the reset entry.
module btb_array
    import fetch_predict_pkg::*;
#(
    parameter int  ADDR_W    = 32,
    parameter int  BTB_DEPTH = 16,
    parameter int  NUM_RD    = 2,
    localparam int IDX_W     = $clog2(BTB_DEPTH),
    localparam int ENTRY_W   = btb_entry_w(ADDR_W, BTB_DEPTH)
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic [NUM_RD-1:0][IDX_W-1:0]   rd_idx,
    output logic [NUM_RD-1:0][ENTRY_W-1:0] rd_entry,
    input  logic                           wr_en,
    input  logic [IDX_W-1:0]               wr_idx,
    input  logic [ENTRY_W-1:0]             wr_entry
);

    // Invalid, zero tag/target, counter weakly not-taken (ctr sits in the LSBs).
    localparam logic [ENTRY_W-1:0] ENTRY_RESET = ENTRY_W'(CTR_RESET);

    logic [ENTRY_W-1:0] mem_q [BTB_DEPTH];
    logic [ENTRY_W-1:0] mem_d [BTB_DEPTH];

    always_comb begin
        for (int i = 0; i < BTB_DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (clr) begin
                mem_d[i] = ENTRY_RESET;
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                mem_d[i] = wr_entry;
            end
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Reads see the pre-write contents; a same-cycle write shows up next cycle.
    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            assign rd_entry[gi] = mem_q[rd_idx[gi]];
        end
    endgenerate

endmodule

// File: rtl/fetch_predict.sv
// Fetch stage with BTB branch prediction: PC register, next-PC select,
// EX-stage resolution, mispredict flush and a saturating mispredict counter.
module fetch_predict
    import fetch_predict_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter int                BTB_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic [ADDR_W-1:0] fetch_pc4,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              ex_valid,
    input  logic              ex_is_branch,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_taken,
    input  logic [ADDR_W-1:0] ex_target,
    input  logic              ex_pred_taken,
    input  logic [ADDR_W-1:0] ex_pred_target,
    output logic              mispredict,
    output logic [STAT_W-1:0] mispredict_count
);

    localparam int IDX_W   = $clog2(BTB_DEPTH);
    localparam int TAG_W   = btb_tag_w(ADDR_W, BTB_DEPTH);
    localparam int ENTRY_W = btb_entry_w(ADDR_W, BTB_DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] target;
        ctr_e              ctr;
    } btb_entry_t;

    logic [ADDR_W-1:0]           pc_q, pc_d;
    logic [STAT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]            fetch_idx, ex_idx;
    logic [TAG_W-1:0]            fetch_tag, ex_tag;
    logic [1:0][IDX_W-1:0]       rd_idx;
    logic [1:0][ENTRY_W-1:0]     rd_entry;
    btb_entry_t                  fetch_entry, ex_entry, wr_entry;
    logic                        fetch_hit, ex_hit, wr_en;
    logic                        dir_wrong, tgt_wrong;
    logic [ADDR_W-1:0]           ex_pc4, redirect_pc;

    function automatic ctr_e ctr_step(input ctr_e c, input logic taken);
        ctr_e r;
        case (c)
            CTR_SNT: r = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: r = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  r = taken ? CTR_ST  : CTR_WNT;
            default: r = taken ? CTR_ST  : CTR_WT;
        endcase
        return r;
    endfunction

    assign fetch_idx = pc_q[IDX_W+1:2];
    assign fetch_tag = pc_q[ADDR_W-1:IDX_W+2];
    assign ex_idx    = ex_pc[IDX_W+1:2];
    assign ex_tag    = ex_pc[ADDR_W-1:IDX_W+2];
    assign rd_idx    = {ex_idx, fetch_idx};

    btb_array #(
        .ADDR_W    (ADDR_W),
        .BTB_DEPTH (BTB_DEPTH),
        .NUM_RD    (2)
    ) u_btb (
        .clk      (clk),
        .clr      (reset),
        .rd_idx   (rd_idx),
        .rd_entry (rd_entry),
        .wr_en    (wr_en),
        .wr_idx   (ex_idx),
        .wr_entry (wr_entry)
    );

    assign fetch_entry = btb_entry_t'(rd_entry[0]);
    assign ex_entry    = btb_entry_t'(rd_entry[1]);
    assign fetch_hit   = fetch_entry.valid && (fetch_entry.tag == fetch_tag);
    assign ex_hit      = ex_entry.valid && (ex_entry.tag == ex_tag);

    assign fetch_pc    = pc_q;
    assign fetch_pc4   = pc_q + PC_STEP;
    assign pred_taken  = fetch_hit && (fetch_entry.ctr >= CTR_WT);
    assign pred_target = fetch_hit ? fetch_entry.target : '0;

    // A non-branch that was predicted taken is a BTB alias and must be undone.
    assign ex_pc4      = ex_pc + PC_STEP;
    assign dir_wrong   = ex_taken != ex_pred_taken;
    assign tgt_wrong   = ex_taken && ex_pred_taken && (ex_target != ex_pred_target);
    assign mispredict  = ex_valid && (ex_is_branch ? (dir_wrong || tgt_wrong) : ex_pred_taken);
    assign redirect_pc = (ex_is_branch && ex_taken) ? ex_target : ex_pc4;

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = ex_entry;
        if (ex_valid && !reset) begin
            if (ex_is_branch) begin
                if (ex_hit) begin
                    wr_en        = 1'b1;
                    wr_entry.ctr = ctr_step(ex_entry.ctr, ex_taken);
                    if (ex_taken) begin
                        wr_entry.target = ex_target;
                    end
                end else if (ex_taken) begin
                    wr_en           = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = ex_tag;
                    wr_entry.target = ex_target;
                    wr_entry.ctr    = CTR_ALLOC;
                end
            end else if (ex_hit) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b0;
            end
        end
    end

    always_comb begin
        if (mispredict) begin
            pc_d = redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end else begin
            pc_d = fetch_pc4;
        end
        cnt_d = cnt_q;
        if (mispredict && (cnt_q != {STAT_W{1'b1}})) begin
            cnt_d = cnt_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign mispredict_count = cnt_q;

endmodule

// File: tb/tb_fetch_predict.sv
// Directed bench for fetch_predict: the driver queues hand-computed per-cycle
// expectations and a negedge monitor pops and compares them.
module tb_fetch_predict;

    localparam int AW = 32;
    localparam int SW = 4;
    localparam logic [4:0] M_PC  = 5'b00001;
    localparam logic [4:0] M_PT  = 5'b00010;
    localparam logic [4:0] M_TG  = 5'b00100;
    localparam logic [4:0] M_MIS = 5'b01000;
    localparam logic [4:0] M_CNT = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    logic          clk = 1'b0;
    logic          reset, stall;
    logic [AW-1:0] fetch_pc, fetch_pc4, pred_target;
    logic          pred_taken;
    logic          ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [AW-1:0] ex_pc, ex_target, ex_pred_target;
    logic          mispredict;
    logic [SW-1:0] mispredict_count;

    typedef struct {
        string         name;
        logic [4:0]    mask;
        logic [AW-1:0] pc;
        logic          pt;
        logic [AW-1:0] tgt;
        logic          mis;
        logic [SW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    fetch_predict #(
        .ADDR_W    (AW),
        .BTB_DEPTH (16),
        .RESET_PC  (32'h100),
        .STAT_W    (SW)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .fetch_pc         (fetch_pc),
        .fetch_pc4        (fetch_pc4),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex_valid         (ex_valid),
        .ex_is_branch     (ex_is_branch),
        .ex_pc            (ex_pc),
        .ex_taken         (ex_taken),
        .ex_target        (ex_target),
        .ex_pred_taken    (ex_pred_taken),
        .ex_pred_target   (ex_pred_target),
        .mispredict       (mispredict),
        .mispredict_count (mispredict_count)
    );

    always #5 clk = ~clk;

    initial begin
        #20000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input string fld,
                       input logic [AW-1:0] act, input logic [AW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.mask[0]) begin
                chk(e.name, "fetch_pc", fetch_pc, e.pc);
                chk(e.name, "fetch_pc4", fetch_pc4, e.pc + 32'd4);
            end
            if (e.mask[1]) chk(e.name, "pred_taken", AW'(pred_taken), AW'(e.pt));
            if (e.mask[2]) chk(e.name, "pred_target", pred_target, e.tgt);
            if (e.mask[3]) chk(e.name, "mispredict", AW'(mispredict), AW'(e.mis));
            if (e.mask[4]) chk(e.name, "count", AW'(mispredict_count), AW'(e.cnt));
            $display("txn %-12s pc=%h pt=%b tgt=%h mis=%b cnt=%0d", e.name,
                     fetch_pc, pred_taken, pred_target, mispredict, mispredict_count);
        end
    end

    task automatic step(input string nm, input bit rst, input bit stl,
                        input bit v, input bit br, input logic [AW-1:0] epc,
                        input bit tk, input logic [AW-1:0] etg,
                        input bit ptk, input logic [AW-1:0] ptg,
                        input logic [4:0] mask, input logic [AW-1:0] xpc,
                        input bit xpt, input logic [AW-1:0] xtg,
                        input bit xmis, input int xcnt);
        exp_t e;
        reset          = rst;
        stall          = stl;
        ex_valid       = v;
        ex_is_branch   = br;
        ex_pc          = epc;
        ex_taken       = tk;
        ex_target      = etg;
        ex_pred_taken  = ptk;
        ex_pred_target = ptg;
        e.name = nm;
        e.mask = mask;
        e.pc   = xpc;
        e.pt   = xpt;
        e.tgt  = xtg;
        e.mis  = xmis;
        e.cnt  = SW'(xcnt);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input bit stl, input logic [4:0] mask,
                        input logic [AW-1:0] xpc, input bit xpt,
                        input logic [AW-1:0] xtg, input int xcnt);
        step(nm, 1'b0, stl, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0,
             mask, xpc, xpt, xtg, 1'b0, xcnt);
    endtask

    task automatic rs(input string nm, input bit stl, input bit br,
                      input logic [AW-1:0] epc, input bit tk, input logic [AW-1:0] etg,
                      input bit ptk, input logic [AW-1:0] ptg,
                      input logic [4:0] mask, input logic [AW-1:0] xpc,
                      input bit xpt, input logic [AW-1:0] xtg,
                      input bit xmis, input int xcnt);
        step(nm, 1'b0, stl, 1'b1, br, epc, tk, etg, ptk, ptg,
             mask, xpc, xpt, xtg, xmis, xcnt);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; ex_valid = 1'b0; ex_is_branch = 1'b0;
        ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
        ex_pred_taken = 1'b0; ex_pred_target = '0;
        @(posedge clk);
        #1;

        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, M_ALL, 32'h100, 0, 0, 0, 0);
        idle("release", 0, M_ALL, 32'h100, 0, 0, 0);
        idle("pc_plus4", 0, M_ALL, 32'h104, 0, 0, 0);

        rs("cold_br",  0, 1, 32'h20, 1, 32'h80, 0, 0,      M_ALL, 32'h108, 0, 0, 1, 0);
        rs("redir20a", 0, 1, 32'h1C, 0, 0,      1, 32'h20, M_ALL, 32'h80,  0, 0, 1, 1);
        idle("hit20", 0, M_ALL, 32'h20, 1, 32'h80, 2);
        idle("follow", 0, M_ALL, 32'h80, 0, 0, 2);

        for (int k = 0; k < 3; k++)
            rs("sat_taken", 0, 1, 32'h20, 1, 32'h80, 1, 32'h80,
               M_ALL, 32'h84 + 32'(4 * k), 0, 0, 0, 2);
        rs("nt_first", 0, 1, 32'h20, 0, 32'h80, 1, 32'h80, M_ALL, 32'h90, 0, 0, 1, 2);
        rs("redir20b", 0, 1, 32'h1C, 0, 0,      1, 32'h20, M_ALL, 32'h24, 0, 0, 1, 3);
        idle("wt_hit", 0, M_ALL, 32'h20, 1, 32'h80, 4);
        rs("nt_second", 0, 1, 32'h20, 0, 32'h80, 1, 32'h80, M_ALL, 32'h80, 0, 0, 1, 4);
        rs("redir20c",  0, 1, 32'h1C, 0, 0,      1, 32'h20, M_ALL, 32'h24, 0, 0, 1, 5);
        idle("wnt_hit", 0, M_ALL, 32'h20, 0, 32'h80, 6);

        rs("redir44", 0, 1, 32'h40, 0, 0, 1, 32'h44, M_ALL, 32'h24, 0, 0, 1, 6);
        idle("stall", 1, M_ALL, 32'h44, 0, 0, 7);
        rs("stall_mis", 1, 1, 32'h50, 1, 32'h200, 0, 0, M_ALL, 32'h44, 0, 0, 1, 7);
        idle("redir200", 0, M_ALL, 32'h200, 0, 0, 8);

        rs("alias",     0, 0, 32'h20, 0, 0,      1, 32'h80, M_ALL, 32'h204, 0, 0, 1, 8);
        rs("redir20d",  0, 1, 32'h1C, 0, 0,      1, 32'h20, M_ALL, 32'h24,  0, 0, 1, 9);
        rs("realloc20", 0, 1, 32'h20, 1, 32'h80, 0, 0,      M_ALL, 32'h20,  0, 0, 1, 10);
        rs("redir60",   0, 1, 32'h5C, 0, 0,      1, 32'h60, M_ALL, 32'h80,  0, 0, 1, 11);
        idle("miss60", 0, M_ALL, 32'h60, 0, 0, 12);

        for (int i = 0; i < 20; i++)
            rs("stat_sat", 0, 1, 32'h1C, 0, 0, 1, 32'h20, M_MIS | M_CNT,
               0, 0, 0, 1, (12 + i > 15) ? 15 : 12 + i);
        idle("stat_hold", 0, M_ALL, 32'h20, 1, 32'h80, 15);

        step("rst_override", 1, 1, 1, 1, 32'h100, 1, 32'h300, 0, 0,
             M_ALL, 32'h80, 0, 0, 1, 15);
        idle("post_rst", 0, M_ALL, 32'h100, 0, 0, 0);
        idle("post_rst4", 0, M_ALL, 32'h104, 0, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
        end
        #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
